// File: rtl/seq_div_pkg.sv
// ============================================================================
// Module      : seq_div_pkg
// Description : Shared constants, FSM state type and two's-complement helpers
//               for the sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_div_pkg;

    // Operand / result width
    localparam int WIDTH = 16;

    // Iteration counter width: enough to hold WIDTH-1
    localparam int CNT_W = 4;

    // Counter value loaded on an accepted start (one quotient bit per count)
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    // Controller states; FIXUP is only reachable in the signed build
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Two's-complement negation, modulo 2^WIDTH
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Absolute value of a two's-complement operand; 16'h8000 maps to itself,
    // which is the correct unsigned magnitude
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? twos_neg(v) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
// Module      : seq_divider_if
// Description : Request/result bundle of the sequential divider. The master
//               issues start and operands; the slave (divider) returns
//               status, results and controller strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_divider_if;
    import seq_div_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             sub_signal;
    logic             shift_signal;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder,
               sub_signal, shift_signal
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder,
               sub_signal, shift_signal
    );

endinterface

`default_nettype wire

// File: rtl/seq_div_controller.sv
// ============================================================================
// Module      : seq_div_controller
// Description : FSM and iteration counter of the sequential divider. Produces
//               datapath enables, busy/done and the sub/shift strobes.
//               Build option SEQ_DIV_SIGNED_EN adds the FIXUP state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div_controller
    import seq_div_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic divisor_zero,
    input  logic trial_ok,
    output logic load,
    output logic iter_en,
`ifdef SEQ_DIV_SIGNED_EN
    output logic fixup_en,
`else
    output logic last_iter,
`endif
    output logic busy,
    output logic done,
    output logic sub_signal,
    output logic shift_signal
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             count_zero;

    assign count_zero = (count == '0);

    // State register; reset abandons any division in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Iteration counter: loaded on accept, counts down once per ITER cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_LOAD;
        end else if (state == ITER && !count_zero) begin
            count <= count - 1'b1;
        end
    end

    // Next-state logic; a zero divisor bypasses the iterations entirely
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : ITER;
                end
            end
            ITER: begin
                if (count_zero) begin
`ifdef SEQ_DIV_SIGNED_EN
                    state_next = FIXUP;
`else
                    state_next = DONE;
`endif
                end
            end
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore-style decodes plus the sub strobe qualified by the trial result
    always_comb begin
        load         = (state == IDLE) && start;
        iter_en      = (state == ITER);
`ifdef SEQ_DIV_SIGNED_EN
        fixup_en     = (state == FIXUP);
        busy         = (state == ITER) || (state == FIXUP);
`else
        last_iter    = (state == ITER) && count_zero;
        busy         = (state == ITER);
`endif
        done         = (state == DONE);
        shift_signal = (state == ITER);
        sub_signal   = (state == ITER) && trial_ok;
    end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : 16-bit restoring shift-subtract divider, one quotient bit per
//               clock, MSB first. Holds operand/partial-remainder registers
//               and result registers; sequencing lives in seq_div_controller.
//               Build option SEQ_DIV_SIGNED_EN: two's-complement operands,
//               magnitude division followed by a sign FIXUP cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import seq_div_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);

    logic             load;
    logic             iter_en;
`ifdef SEQ_DIV_SIGNED_EN
    logic             fixup_en;
    logic             neg_quo;
    logic             neg_rem;
`else
    logic             last_iter;
`endif
    logic             divisor_zero;
    logic             trial_ok;

    logic [WIDTH:0]   part_rem;    // 17-bit partial remainder
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dq;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH+1:0] trial_diff;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             dz_reg;

    assign divisor_zero = (bus.divisor == '0);

    seq_div_controller u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .start        (bus.start),
        .divisor_zero (divisor_zero),
        .trial_ok     (trial_ok),
        .load         (load),
        .iter_en      (iter_en),
`ifdef SEQ_DIV_SIGNED_EN
        .fixup_en     (fixup_en),
`else
        .last_iter    (last_iter),
`endif
        .busy         (bus.busy),
        .done         (bus.done),
        .sub_signal   (bus.sub_signal),
        .shift_signal (bus.shift_signal)
    );

    // Shift {part_rem, dq} left one place and trial-subtract the divisor;
    // the extra top bit of the difference acts as the borrow
    assign trial_diff = {part_rem, dq[WIDTH-1]} - {2'b00, dvs};
    assign trial_ok   = ~trial_diff[WIDTH+1];
    assign rem_next   = trial_ok ? trial_diff[WIDTH:0]
                                 : {part_rem[WIDTH-1:0], dq[WIDTH-1]};
    assign quo_next   = {dq[WIDTH-2:0], trial_ok};

    // Operand capture on accept, then one restoring step per ITER cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            part_rem <= '0;
            dq       <= '0;
            dvs      <= '0;
        end else if (load) begin
            part_rem <= '0;
`ifdef SEQ_DIV_SIGNED_EN
            dq       <= magnitude(bus.dividend);
            dvs      <= magnitude(bus.divisor);
`else
            dq       <= bus.dividend;
            dvs      <= bus.divisor;
`endif
        end else if (iter_en) begin
            part_rem <= rem_next;
            dq       <= quo_next;
        end
    end

`ifdef SEQ_DIV_SIGNED_EN
    // Result signs: quotient negative when operand signs differ, remainder
    // follows the dividend (truncation toward zero)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (load) begin
            neg_quo <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_rem <= bus.dividend[WIDTH-1];
        end
    end
`endif

    // Result registers: divide-by-zero result set at accept, normal result
    // written when the last bit (or the sign fixup) completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_reg <= '0;
            rem_reg <= '0;
            dz_reg  <= 1'b0;
        end else if (load) begin
            dz_reg <= divisor_zero;
            if (divisor_zero) begin
                quo_reg <= '1;
                rem_reg <= bus.dividend;
            end
`ifdef SEQ_DIV_SIGNED_EN
        end else if (fixup_en) begin
            quo_reg <= neg_quo ? twos_neg(dq) : dq;
            rem_reg <= neg_rem ? twos_neg(part_rem[WIDTH-1:0])
                               : part_rem[WIDTH-1:0];
`else
        end else if (last_iter) begin
            quo_reg <= quo_next;
            rem_reg <= rem_next[WIDTH-1:0];
`endif
        end
    end

    assign bus.quotient    = quo_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dz_reg;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider: vector table driven
//               through a scoreboard queue, plus hand sequences for ignored
//               start, held start and mid-operation reset.
//               Honours SEQ_DIV_SIGNED_EN for the signed build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seq_divider;
    import seq_div_pkg::*;

`ifdef SEQ_DIV_SIGNED_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          subs;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          subs;
        int          shifts;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   sub_cnt = 0;
    int   shift_cnt = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_divider_if bus ();

    seq_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [15:0] q, input logic [15:0] r,
                                    input logic dz, input int subs);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.subs = subs;
        e.shifts = dz ? 0 : 16;
        return e;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_busy"},  {31'd0, bus.busy}, 0);
        check({name, "_done"},  {31'd0, bus.done}, 0);
        check({name, "_dz"},    {31'd0, bus.div_by_zero}, 0);
        check({name, "_quo"},   {16'd0, bus.quotient}, 0);
        check({name, "_rem"},   {16'd0, bus.remainder}, 0);
        check({name, "_sub"},   {31'd0, bus.sub_signal}, 0);
        check({name, "_shift"}, {31'd0, bus.shift_signal}, 0);
    endtask

    // Drive operands and raise start; call just after a falling edge in IDLE
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input exp_t e, input bit push);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        if (push) sb_q.push_back(e);
    endtask

    // Count falling edges until done; optionally fire a stray start mid-run
    task automatic wait_done(input int exp_wait, input int stray_at,
                             input bit hold, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && !hold) bus.start = 1'b0;
            if (stray_at > 0 && n == stray_at) begin
                bus.start = 1'b1; bus.dividend = 16'd3; bus.divisor = 16'd3;
            end
            if (stray_at > 0 && n == stray_at + 1) bus.start = 1'b0;
        end while (!bus.done && n < 60);
        check({name, "_latency"}, n, exp_wait);
    endtask

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            sub_cnt   = 0;
            shift_cnt = 0;
        end else begin
            if (bus.shift_signal) shift_cnt++;
            if (bus.sub_signal)   sub_cnt++;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("quotient",    {16'd0, bus.quotient}, {16'd0, e.q});
                    check("remainder",   {16'd0, bus.remainder}, {16'd0, e.r});
                    check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
                    check("busy_at_done", {31'd0, bus.busy}, 0);
                    check("sub_count",   sub_cnt, e.subs);
                    check("shift_count", shift_cnt, e.shifts);
                end
                sub_cnt   = 0;
                shift_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dones;
        exp_t e;

        // vector table: {dividend, divisor, quotient, remainder, dz, sub strobes}
        vecs.push_back('{16'h0080, 16'h0010, 16'h0008, 16'h0000, 1'b0, 1});
        vecs.push_back('{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 3});
        vecs.push_back('{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 0});
        vecs.push_back('{16'h0000, 16'd5,    16'h0000, 16'h0000, 1'b0, 0});
        vecs.push_back('{16'd5,    16'd9,    16'h0000, 16'd5,    1'b0, 0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1});
        vecs.push_back('{16'd1000, 16'd33,   16'd30,   16'd10,   1'b0, 4});
`ifdef SEQ_DIV_SIGNED_EN
        vecs.push_back('{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 2});
        vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1});
        vecs.push_back('{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 2});
        vecs.push_back('{16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 2});
        vecs.push_back('{16'hFFF0, 16'h0000, 16'hFFFF, 16'hFFF0, 1'b1, 0});
`else
        vecs.push_back('{16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0, 5});
        vecs.push_back('{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16});
`endif

        reset = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        #2 reset = 1'b1;
        @(negedge clk);

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].a, vecs[i].b,
                  mk_exp(vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].subs), 1'b1);
            wait_done(vecs[i].dz ? 1 : LAT + 1, 0, 1'b0, $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // stray start during iteration 5 must be ignored
`ifdef SEQ_DIV_SIGNED_EN
        e = mk_exp(16'hFFFF, 16'h0000, 1'b0, 1);
`else
        e = mk_exp(16'hFFFF, 16'h0000, 1'b0, 16);
`endif
        issue(16'hFFFF, 16'h0001, e, 1'b1);
        wait_done(LAT + 1, 5, 1'b0, "stray");
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("stray_extra_done", dones, 0);

        // start held high: second division begins on the IDLE after DONE
        issue(16'd1000, 16'd33, mk_exp(16'd30, 16'd10, 1'b0, 4), 1'b1);
        sb_q.push_back(mk_exp(16'h001B, 16'h00CD, 1'b0, 4));
        @(negedge clk);
        bus.dividend = 16'h1BCD;
        bus.divisor  = 16'h0100;
        wait_done(LAT, 0, 1'b1, "held_a");
        @(negedge clk);
        check("held_idle_busy", {31'd0, bus.busy}, 0);
        @(negedge clk);
        check("held_accept_busy", {31'd0, bus.busy}, 1);
        bus.start = 1'b0;
        wait_done(LAT, 0, 1'b0, "held_b");
        @(negedge clk);

        // reset at iteration 8 abandons the division
        issue(16'd100, 16'd7, mk_exp(16'd14, 16'd2, 1'b0, 3), 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", {31'd0, bus.busy}, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("reset_no_done", dones, 0);
        issue(16'd100, 16'd7, mk_exp(16'd14, 16'd2, 1'b0, 3), 1'b1);
        wait_done(LAT + 1, 0, 1'b0, "post_reset");
        @(negedge clk);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
